// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        FIN
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words
// and compares them against expected values to gate boot.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECT_ID      = 32'h0000_0000,
    parameter logic [31:0] EXPECT_TS      = 32'h0000_0000,
    parameter bit          CHECK_TS       = 1'b1,
    parameter bit          AUTOSTART      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        first_q;
    logic        addr_q, read_q, busy_q, done_q, pass_q;
    logic        id_match_q, ts_match_q, timeout_q;
    logic [31:0] id_value_q, ts_value_q;

    logic in_req, in_wait, is_id, accept, rd_done, expired;

    always_comb begin
        in_req  = (state_q == REQ_ID)  || (state_q == REQ_TS);
        in_wait = (state_q == WAIT_ID) || (state_q == WAIT_TS);
        is_id   = (state_q == REQ_ID)  || (state_q == WAIT_ID);
        accept  = in_req && read_q && !avm_waitrequest;
        // Data counts in REQ only when the request is accepted in the same cycle.
        rd_done = avm_readdatavalid && (accept || in_wait);
        expired = (cnt_q == TO_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            addr_q     <= SYSID_ADDR_ID;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            first_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start || (AUTOSTART && first_q)) begin
                        state_q    <= REQ_ID;
                        busy_q     <= 1'b1;
                        read_q     <= 1'b1;
                        addr_q     <= SYSID_ADDR_ID;
                        cnt_q      <= '0;
                        pass_q     <= 1'b0;
                        id_match_q <= 1'b0;
                        ts_match_q <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (rd_done) begin
                        if (is_id) begin
                            id_value_q <= avm_readdata;
                            id_match_q <= (avm_readdata == EXPECT_ID);
                            state_q    <= REQ_TS;
                            read_q     <= 1'b1;
                            addr_q     <= SYSID_ADDR_TS;
                            cnt_q      <= '0;
                        end else begin
                            ts_value_q <= avm_readdata;
                            ts_match_q <= (avm_readdata == EXPECT_TS);
                            state_q    <= FIN;
                            read_q     <= 1'b0;
                        end
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        read_q    <= 1'b0;
                        state_q   <= FIN;
                    end else if (accept) begin
                        read_q  <= 1'b0;
                        state_q <= is_id ? WAIT_ID : WAIT_TS;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= id_match_q && (ts_match_q || !CHECK_TS) && !timeout_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_match    = id_match_q;
    assign ts_match    = ts_match_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule
